// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame path: FSM encoding, frame geometry,
// and source indices.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam int unsigned BYTES_PER_LED = 3;

  localparam logic SRC_BG  = 1'b0;
  localparam logic SRC_OVL = 1'b1;

endpackage

// File: rtl/ws2812_gap_timer.sv
// Loadable down-counter that times the WS2812 latch gap.
// Ports: clk, rst (sync, active-high); load/load_val preset the count;
// dec counts down (holds at zero); done_c is high while the count is zero.
module ws2812_gap_timer
  import ws2812_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done_c
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Shares one WS2812 byte serializer between a background source (src0) and a
// priority overlay source (src1). Grants last a whole frame, every frame is
// followed by a latch gap, and src0 is guaranteed a frame after MAX_CONSEC
// back-to-back src1 frames while it waits.
// Ports: clk, rst (sync, active-high); src_trigger/src_color from the sources,
// src_data_request back to them; drv_trigger/drv_color to the serializer,
// drv_data_request from it; active_src, busy, frame_done status.
module ws2812_frame_arbiter
  import ws2812_pkg::*;
#(
  parameter int unsigned LEDS       = 32,
  parameter int unsigned RESET_GAP  = 2500,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  src_trigger,
  input  logic [15:0] src_color,
  output logic [1:0]  src_data_request,
  output logic        drv_trigger,
  output logic [7:0]  drv_color,
  input  logic        drv_data_request,
  output logic        active_src,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned FRAME_BYTES = LEDS * BYTES_PER_LED;
  localparam int unsigned BCW = $clog2(FRAME_BYTES);
  localparam int unsigned GW  = (RESET_GAP > 1) ? $clog2(RESET_GAP) : 1;
  localparam int unsigned CW  = $clog2(MAX_CONSEC + 1);

  state_t         state, state_nxt;
  logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
  logic [CW-1:0]  consec, consec_nxt;
  logic           active_nxt;
  logic           gap_load, gap_dec, gap_done;

  ws2812_gap_timer #(.W(GW)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GW'(RESET_GAP - 1)),
    .dec      (gap_dec),
    .done_c   (gap_done)
  );

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      consec     <= '0;
      active_src <= SRC_BG;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= byte_cnt_nxt;
      consec     <= consec_nxt;
      active_src <= active_nxt;
    end
  end

  // Next state, counters and the serializer-facing mux.
  always_comb begin
    state_nxt        = state;
    byte_cnt_nxt     = byte_cnt;
    consec_nxt       = consec;
    active_nxt       = active_src;
    gap_load         = 1'b0;
    gap_dec          = 1'b0;
    drv_trigger      = 1'b0;
    drv_color        = 8'd0;
    src_data_request = 2'b00;
    frame_done       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (src_trigger != 2'b00) begin
          // Overlay wins unless the background has waited out its quota.
          if (src_trigger[1] && !(src_trigger[0] && (consec == CW'(MAX_CONSEC))))
            active_nxt = SRC_OVL;
          else
            active_nxt = SRC_BG;
          byte_cnt_nxt = '0;
          state_nxt    = ST_STREAM;
        end
      end

      ST_STREAM: begin
        drv_trigger      = src_trigger[active_src];
        drv_color        = active_src ? src_color[15:8] : src_color[7:0];
        src_data_request = active_src ? {drv_data_request, 1'b0}
                                      : {1'b0, drv_data_request};
        if (drv_data_request) begin
          if (byte_cnt == BCW'(FRAME_BYTES - 1)) begin
            frame_done   = 1'b1;
            gap_load     = 1'b1;
            byte_cnt_nxt = '0;
            state_nxt    = ST_GAP;
            // Only overlay frames that made the background wait count.
            if ((active_src == SRC_OVL) && src_trigger[0])
              consec_nxt = (consec == CW'(MAX_CONSEC)) ? consec : consec + CW'(1);
            else
              consec_nxt = '0;
          end else begin
            byte_cnt_nxt = byte_cnt + BCW'(1);
          end
        end
      end

      ST_GAP: begin
        gap_dec = 1'b1;
        if (gap_done)
          state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/ws2812_frame_arbiter.md
Name: ws2812_frame_arbiter

Overview:
- Shares one WS2812 serializer between two frame sources: src0 is the background generator (fancy fader); src1 is the priority overlay/notification generator.
- Grants are per whole strip frame and are never switched mid-frame.
- Enforces a minimum latch gap after every frame.
- Guards src0 against starvation by src1.
- Sits between the pattern generators and the WS2812 byte serializer.

Parameters:
- LEDS, 32, LEDs per strip; one frame = LEDS*3 bytes.
- RESET_GAP, 2500, idle cycles forced after each frame before the next grant (WS2812 latch time).
- MAX_CONSEC, 4, maximum back-to-back src1 frames while src0 is pending; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- src_trigger  in  2  per-source "frame ready, stream me" level; bit i = source i
- src_color  in  16  packed byte per source; [7:0] = src0, [15:8] = src1; combinational, valid while granted
- src_data_request  out  2  one-cycle pulse to the granted source only: current byte consumed
- drv_trigger  out  1  to serializer: byte available; serializer consumes only while high
- drv_color  out  8  byte to serializer
- drv_data_request  in  1  serializer pulse: byte on drv_color taken this cycle
- active_src  out  1  index of the current/last granted source
- busy  out  1  high in STREAM or GAP
- frame_done  out  1  one-cycle pulse on the last byte of a frame

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. Rst wins over all other activity, including mid-frame.
- Reset values: state=IDLE, byte_cnt=0, gap_cnt=0, consec=0, active_src=0. All outputs 0, drv_color=0.
- States: IDLE, STREAM, GAP (2-bit encoding).
- IDLE, grant selection (evaluated each cycle):
  - If src_trigger==0: stay in IDLE.
  - Else choose src1 if src_trigger[1] && !(src_trigger[0] && consec==MAX_CONSEC); otherwise choose src0.
  - Register the choice into active_src, clear byte_cnt, go to STREAM next cycle.
  - Latency: trigger seen at cycle N; drv_trigger can be high at N+1.
- STREAM outputs (combinational from the registered grant):
  - drv_trigger = src_trigger[active_src].
  - drv_color = src_color byte of active_src.
  - src_data_request[active_src] = drv_data_request; the other bit is 0.
- STREAM byte counting:
  - On each drv_data_request, byte_cnt increments.
  - At byte_cnt==LEDS*3-1 with request: pulse frame_done, load gap_cnt=RESET_GAP-1, go to GAP.
  - If the granted source drops trigger mid-frame: drv_trigger goes low, the arbiter stays in STREAM holding byte_cnt, and resumes when trigger returns. No timeout, no regrant.
- GAP: drv_trigger=0, no src_data_request. gap_cnt decrements; at 0 go to IDLE. RESET_GAP=0 is illegal.
- Starvation counter, updated on frame_done:
  - src1 frame while src_trigger[0] was high: consec += 1, saturating at MAX_CONSEC.
  - src0 frame: consec=0.
  - src1 frame while src0 was not pending: consec=0.
- In IDLE and GAP: drv_trigger=0, drv_color=0, src_data_request=0. A drv_data_request arriving in these states is ignored and never forwarded.
- busy = (state != IDLE).
- Widths:
  - byte_cnt is $clog2(LEDS*3) bits.
  - gap_cnt is $clog2(RESET_GAP) bits, minimum 1.
  - consec is $clog2(MAX_CONSEC+1) bits.
  - All comparisons are unsigned; there is no wrap because the terminal count is reached first.

Decomposition:
- Shared package ws2812_pkg holds:
  - State encoding constants ST_IDLE, ST_STREAM, ST_GAP.
  - BYTES_PER_LED=3.
  - Source index constants SRC_BG=0, SRC_OVL=1.
- One natural sub-module, ws2812_gap_timer: loadable down-counter with a done flag, used for the GAP state. Everything else stays flat.

Test Plan (LEDS=4 so 12 bytes, RESET_GAP=5, MAX_CONSEC=2, serializer model requests a byte every 3rd cycle):
- src0 only triggers at cycle 10 -> active_src=0 and drv_trigger=1 at 11; 12 src_data_request[0] pulses, src_data_request[1] stays 0; frame_done on the 12th; drv_trigger=0 for 5 cycles; busy=0 afterwards.
- Both triggers rise together in IDLE -> src1 granted; drv_color equals src_color[15:8]; src0 receives no requests.
- Both triggers held high continuously -> grant order src1, src1, src0, src1, src1, src0; consec saturates at 2.
- src1 drops trigger after 5 bytes for 20 cycles -> drv_trigger=0, byte_cnt holds at 5; after resume, exactly 7 more bytes, then frame_done.
- rst asserted at byte 6 of a frame -> next cycle state=IDLE and all outputs 0; the following trigger starts a fresh 12-byte frame.
- drv_data_request pulsed during GAP and IDLE -> no src_data_request pulse, byte_cnt unchanged.
